// File: rtl/overflow_accumulator_if.sv
// Stream bundle for overflow_accumulator: operand input handshake, start
// strobe and the registered frame result with its overflow status.
interface overflow_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int CW    = $clog2(COUNT + 1)
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;
  logic [CW-1:0]    out_ovf_count;

  // Operand source / result consumer side
  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow, out_ovf_count
  );

  // Accumulator side
  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_overflow, out_ovf_count
  );
endinterface

// File: rtl/overflow_accumulator.sv
// Sequential multi-operand adder: sums a frame of COUNT unsigned operands
// into a WIDTH-bit accumulator, counting every carry-out and either wrapping
// or clamping to all-ones on overflow.
module overflow_accumulator #(
  parameter int WIDTH    = 8,
  parameter int COUNT    = 4,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  overflow_accumulator_if.slave   bus
);
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    opnd_cnt;
  logic             ovf_flag;
  logic [CW-1:0]    ovf_cnt;
  logic [WIDTH:0]   sum_ext;
  logic             carry;
  logic             accept;

  // One extra bit holds the carry-out of acc + operand.
  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Clamp to all-ones when saturating, otherwise drop the carry (wrap).
  function automatic logic [WIDTH-1:0] wrap_or_sat(input logic [WIDTH:0] s);
    if ((SATURATE != 0) && s[WIDTH])
      return '1;
    return s[WIDTH-1:0];
  endfunction

  assign sum_ext = add_carry(acc, bus.in_data);
  assign carry   = sum_ext[WIDTH];
  // in_ready is a pure state decode, so the accept term never feeds an output.
  assign accept  = (state == ACC) && bus.in_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = ACC;
      ACC: begin
        bus.in_ready = 1'b1;
        if (accept && (opnd_cnt == LAST)) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, operand counter and overflow status; cleared on start so
  // results persist after DONE until the next frame begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opnd_cnt <= '0;
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else if ((state == IDLE) && bus.start) begin
      acc      <= '0;
      opnd_cnt <= '0;
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
    end else if (accept) begin
      acc      <= wrap_or_sat(sum_ext);
      opnd_cnt <= opnd_cnt + CW'(1);
      if (carry) begin
        ovf_flag <= 1'b1;
        ovf_cnt  <= ovf_cnt + CW'(1);
      end
    end
  end

  assign bus.out_sum       = acc;
  assign bus.out_overflow  = ovf_flag;
  assign bus.out_ovf_count = ovf_cnt;
endmodule

// File: tb/tb_overflow_accumulator.sv
// Bench for overflow_accumulator: two 8-bit/4-operand instances (wrap and
// saturate) share one stimulus stream; a 2-bit/2-operand instance runs its
// own frames. Expected results come from a plain-arithmetic frame model.
module tb_overflow_accumulator;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  overflow_accumulator_if #(.WIDTH(8), .COUNT(4)) ifw ();
  overflow_accumulator_if #(.WIDTH(8), .COUNT(4)) ifs ();
  overflow_accumulator_if #(.WIDTH(2), .COUNT(2)) if2 ();

  overflow_accumulator #(.WIDTH(8), .COUNT(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(ifw));
  overflow_accumulator #(.WIDTH(8), .COUNT(4), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(ifs));
  overflow_accumulator #(.WIDTH(2), .COUNT(2), .SATURATE(0)) u_w2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  assign ifs.start     = ifw.start;
  assign ifs.in_valid  = ifw.in_valid;
  assign ifs.in_data   = ifw.in_data;
  assign ifs.out_ready = ifw.out_ready;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  // Frame model. Wrap mode: the true sum split into quotient (carries) and
  // remainder (result). Saturate mode: running total clamped at the max,
  // every addition that would exceed it counts as an overflow.
  function automatic void ref_frame(input int ops[4], input int n, input int w,
                                    input bit sat, output int sum, output int cnt);
    int lim;
    int total;
    lim   = (1 << w) - 1;
    total = 0;
    cnt   = 0;
    if (!sat) begin
      for (int i = 0; i < n; i++) total += ops[i];
      sum = total % (lim + 1);
      cnt = total / (lim + 1);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (total + ops[i] > lim) begin
          cnt++;
          total = lim;
        end else begin
          total += ops[i];
        end
      end
      sum = total;
    end
  endfunction

  task automatic check_res8(input string name, input int ws, input int wc,
                            input int ss, input int sc);
    check({name, ".wrap.sum"},  int'(ifw.out_sum), ws);
    check({name, ".wrap.ovf"},  int'(ifw.out_overflow), int'(wc != 0));
    check({name, ".wrap.cnt"},  int'(ifw.out_ovf_count), wc);
    check({name, ".sat.sum"},   int'(ifs.out_sum), ss);
    check({name, ".sat.ovf"},   int'(ifs.out_overflow), int'(sc != 0));
    check({name, ".sat.cnt"},   int'(ifs.out_ovf_count), sc);
  endtask

  // gap < 0 selects a random 0..3 cycle in_valid gap before each operand.
  task automatic run_frame(input string name, input int ops[4], input int gap,
                           input int hold);
    int ws, wc, ss, sc, g;
    ref_frame(ops, 4, 8, 1'b0, ws, wc);
    ref_frame(ops, 4, 8, 1'b1, ss, sc);
    @(negedge clk) ifw.start = 1'b1;
    @(negedge clk) ifw.start = 1'b0;
    check({name, ".in_ready"}, int'(ifw.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
      repeat (g) @(negedge clk);
      ifw.in_valid = 1'b1;
      ifw.in_data  = 8'(ops[i]);
      @(negedge clk);
      ifw.in_valid = 1'b0;
      ifw.in_data  = 8'($urandom);
      if (i < 3) check({name, ".early_valid"}, int'(ifw.out_valid), 0);
    end
    check({name, ".out_valid"}, int'(ifw.out_valid), 1);
    check({name, ".sat.out_valid"}, int'(ifs.out_valid), 1);
    check_res8(name, ws, wc, ss, sc);
    for (int h = 0; h < hold; h++) begin
      ifw.start = 1'($urandom_range(1, 0));
      @(negedge clk);
      check({name, ".hold.valid"}, int'(ifw.out_valid), 1);
      check({name, ".hold.in_ready"}, int'(ifw.in_ready), 0);
      check_res8({name, ".hold"}, ws, wc, ss, sc);
    end
    ifw.start     = 1'b0;
    ifw.out_ready = 1'b1;
    @(negedge clk);
    ifw.out_ready = 1'b0;
    check({name, ".after.valid"}, int'(ifw.out_valid), 0);
    check({name, ".after.sum"}, int'(ifw.out_sum), ws);
  endtask

  task automatic run2(input string name, input int a, input int b);
    int ops[4];
    int es, ec;
    ops = '{a, b, 0, 0};
    ref_frame(ops, 2, 2, 1'b0, es, ec);
    @(negedge clk) if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if2.in_valid = 1'b1;
      if2.in_data  = 2'(ops[i]);
      @(negedge clk);
      if2.in_valid = 1'b0;
    end
    check({name, ".valid"}, int'(if2.out_valid), 1);
    check({name, ".sum"},   int'(if2.out_sum), es);
    check({name, ".ovf"},   int'(if2.out_overflow), int'(ec != 0));
    check({name, ".cnt"},   int'(if2.out_ovf_count), ec);
    if2.out_ready = 1'b1;
    @(negedge clk);
    if2.out_ready = 1'b0;
  endtask

  initial begin
    int d[4];
    rst_n         = 1'b0;
    ifw.start     = 1'b0;
    ifw.in_valid  = 1'b0;
    ifw.in_data   = '0;
    ifw.out_ready = 1'b0;
    if2.start     = 1'b0;
    if2.in_valid  = 1'b0;
    if2.in_data   = '0;
    if2.out_ready = 1'b0;
    #12;
    check("rst.in_ready",  int'(ifw.in_ready), 0);
    check("rst.out_valid", int'(ifw.out_valid), 0);
    check_res8("rst", 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    d = '{10, 20, 30, 40};   run_frame("t1", d, 0, 0);
    d = '{200, 100, 3, 0};   run_frame("t2", d, 0, 0);
    d = '{255, 1, 0, 255};   run_frame("satzero", d, 0, 1);

    run2("t4a", 3, 1);
    run2("t4b", 1, 2);
    for (int k = 0; k < 6; k++)
      run2("w2rnd", int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));

    d = '{90, 80, 70, 60};   run_frame("bp", d, 0, 5);
    d = '{90, 80, 70, 60};   run_frame("gap3", d, 3, 0);

    // Stray operands in IDLE must not touch the held result.
    @(negedge clk);
    ifw.in_valid = 1'b1;
    ifw.in_data  = 8'd77;
    repeat (3) @(negedge clk);
    check("idle.sum",      int'(ifw.out_sum), 44);
    check("idle.in_ready", int'(ifw.in_ready), 0);
    check("idle.valid",    int'(ifw.out_valid), 0);
    ifw.in_valid = 1'b0;

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++)
        d[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(255, 0));
      run_frame("rnd", d, -1, int'($urandom_range(3, 0)));
    end

    // Asynchronous reset after two accepted operands.
    @(negedge clk) ifw.start = 1'b1;
    @(negedge clk) ifw.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifw.in_valid = 1'b1;
      ifw.in_data  = 8'(200);
      @(negedge clk);
    end
    ifw.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.in_ready",  int'(ifw.in_ready), 0);
    check("arst.out_valid", int'(ifw.out_valid), 0);
    check_res8("arst", 0, 0, 0, 0);
    @(negedge clk) #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst.no_result", int'(ifw.out_valid), 0);
    d = '{1, 1, 1, 1};       run_frame("t6", d, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
